// File: rtl/hv_timing_gen.sv
// hv_timing_gen: parametrised raster timing generator.
// Produces pixel/line counters, blanking, active-low syncs and blanked RGB,
// advancing on MCLK edges qualified by the pixel clock-enable PCE. Sync
// positions can be nudged at run time; new offsets take effect only when the
// raster wraps to (0,0) so a frame never sees a half-moved sync.
module hv_timing_gen #(
   parameter int CW          = 9,
   parameter int RGBW        = 12,
   parameter int H_ACTIVE    = 288,
   parameter int H_SKIP_FROM = 342,
   parameter int H_SKIP_TO   = 471,
   parameter int H_LAST      = 511,
   parameter int HS_START    = 311,
   parameter int HS_WIDTH    = 24,
   parameter int V_ACTIVE    = 224,
   parameter int V_SKIP_FROM = 233,
   parameter int V_SKIP_TO   = 483,
   parameter int V_LAST      = 511,
   parameter int VS_START    = 228,
   parameter int VS_WIDTH    = 3,
   parameter int DLY         = 1
) (
   input  logic            MCLK,
   input  logic            RESET,
   input  logic            PCE,
   input  logic [3:0]      HOFS,
   input  logic [2:0]      VOFS,
   input  logic [RGBW-1:0] iRGB,
   output logic [CW-1:0]   HPOS,
   output logic [CW-1:0]   VPOS,
   output logic            HBLK,
   output logic            VBLK,
   output logic            HSYN,
   output logic            VSYN,
   output logic            DE,
   output logic [RGBW-1:0] oRGB,
   output logic            LINE_START,
   output logic            FRAME_START
);

   localparam logic [CW-1:0] L_H_ACTIVE    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] L_H_SKIP_FROM = CW'(H_SKIP_FROM);
   localparam logic [CW-1:0] L_H_SKIP_TO   = CW'(H_SKIP_TO);
   localparam logic [CW-1:0] L_H_LAST      = CW'(H_LAST);
   localparam logic [CW-1:0] L_V_ACTIVE    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] L_V_SKIP_FROM = CW'(V_SKIP_FROM);
   localparam logic [CW-1:0] L_V_SKIP_TO   = CW'(V_SKIP_TO);
   localparam logic [CW-1:0] L_V_LAST      = CW'(V_LAST);

   // Sync start arithmetic is one bit wider and signed so offsets never wrap.
   localparam logic signed [CW:0] L_HS_START = (CW+1)'(HS_START);
   localparam logic signed [CW:0] L_HS_LO    = (CW+1)'(H_ACTIVE);
   localparam logic signed [CW:0] L_HS_HI    = (CW+1)'(H_SKIP_FROM + 1 - HS_WIDTH);
   localparam logic signed [CW:0] L_VS_START = (CW+1)'(VS_START);
   localparam logic signed [CW:0] L_VS_LO    = (CW+1)'(V_ACTIVE);
   localparam logic signed [CW:0] L_VS_HI    = (CW+1)'(V_SKIP_FROM + 1 - VS_WIDTH);
   localparam logic [CW:0]        L_HS_WIDTH = (CW+1)'(HS_WIDTH);
   localparam logic [CW:0]        L_VS_WIDTH = (CW+1)'(VS_WIDTH);

   logic [CW-1:0]     r_hcnt;
   logic [CW-1:0]     r_vcnt;
   logic [CW-1:0]     w_hcntNext;
   logic [CW-1:0]     w_vcntNext;
   logic              w_hWrap;
   logic              w_vWrap;
   logic signed [3:0] r_hofs;
   logic signed [2:0] r_vofs;

   logic signed [CW:0] w_hsSum;
   logic signed [CW:0] w_vsSum;
   logic signed [CW:0] w_hsEff;
   logic signed [CW:0] w_vsEff;
   logic [CW:0]        w_hsEffU;
   logic [CW:0]        w_vsEffU;
   logic [CW:0]        w_hcntExt;
   logic [CW:0]        w_vcntExt;

   logic w_hblkRaw;
   logic w_vblkRaw;
   logic w_hsynRaw;
   logic w_vsynRaw;

   // Pipeline stages; bit 0 of each chain is the raw flag, bit DLY the output.
   logic [DLY-1:0]  r_hblkPipe;
   logic [DLY-1:0]  r_vblkPipe;
   logic [DLY-1:0]  r_hsynPipe;
   logic [DLY-1:0]  r_vsynPipe;
   logic [DLY:0]    w_hblkChain;
   logic [DLY:0]    w_vblkChain;
   logic [DLY:0]    w_hsynChain;
   logic [DLY:0]    w_vsynChain;
   logic [RGBW-1:0] r_rgb;
   logic            r_lineStart;
   logic            r_frameStart;

   assign w_hWrap = (r_hcnt == L_H_LAST);
   assign w_vWrap = (r_vcnt == L_V_LAST);

   // Next counter values: step by one, jump over the skip gap, wrap at the end.
   always_comb begin
      w_hcntNext = r_hcnt + 1'b1;
      w_vcntNext = r_vcnt + 1'b1;
      if (w_hWrap) begin
         w_hcntNext = '0;
      end else if (r_hcnt == L_H_SKIP_FROM) begin
         w_hcntNext = L_H_SKIP_TO;
      end
      if (w_vWrap) begin
         w_vcntNext = '0;
      end else if (r_vcnt == L_V_SKIP_FROM) begin
         w_vcntNext = L_V_SKIP_TO;
      end
   end

   // Counters advance per pixel tick; offsets latch only on the frame wrap.
   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
         r_hofs <= '0;
         r_vofs <= '0;
      end else if (PCE) begin
         r_hcnt <= w_hcntNext;
         if (w_hWrap) begin
            r_vcnt <= w_vcntNext;
         end
         if (w_hWrap && w_vWrap) begin
            r_hofs <= HOFS;
            r_vofs <= VOFS;
         end
      end
   end

   assign w_hsSum = L_HS_START + $signed({{(CW-3){r_hofs[3]}}, r_hofs});
   assign w_vsSum = L_VS_START + $signed({{(CW-2){r_vofs[2]}}, r_vofs});

   // Clamp the shifted sync starts so the pulses stay inside the blanking gap.
   always_comb begin
      w_hsEff = w_hsSum;
      w_vsEff = w_vsSum;
      if (w_hsSum < L_HS_LO) begin
         w_hsEff = L_HS_LO;
      end else if (w_hsSum > L_HS_HI) begin
         w_hsEff = L_HS_HI;
      end
      if (w_vsSum < L_VS_LO) begin
         w_vsEff = L_VS_LO;
      end else if (w_vsSum > L_VS_HI) begin
         w_vsEff = L_VS_HI;
      end
   end

   assign w_hsEffU  = w_hsEff;
   assign w_vsEffU  = w_vsEff;
   assign w_hcntExt = {1'b0, r_hcnt};
   assign w_vcntExt = {1'b0, r_vcnt};

   assign w_hblkRaw = (r_hcnt >= L_H_ACTIVE);
   assign w_vblkRaw = (r_vcnt >= L_V_ACTIVE);
   // Sync flags are carried active-low so the pipeline resets to "inactive" with ones.
   assign w_hsynRaw = ~((w_hcntExt >= w_hsEffU) && (w_hcntExt < (w_hsEffU + L_HS_WIDTH)));
   assign w_vsynRaw = ~((w_vcntExt >= w_vsEffU) && (w_vcntExt < (w_vsEffU + L_VS_WIDTH)));

   assign w_hblkChain = {r_hblkPipe, w_hblkRaw};
   assign w_vblkChain = {r_vblkPipe, w_vblkRaw};
   assign w_hsynChain = {r_hsynPipe, w_hsynRaw};
   assign w_vsynChain = {r_vsynPipe, w_vsynRaw};

   // Delay line aligning flags and RGB with the core's pixel latency.
   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         r_hblkPipe <= '1;
         r_vblkPipe <= '1;
         r_hsynPipe <= '1;
         r_vsynPipe <= '1;
         r_rgb      <= '0;
      end else if (PCE) begin
         r_hblkPipe <= w_hblkChain[DLY-1:0];
         r_vblkPipe <= w_vblkChain[DLY-1:0];
         r_hsynPipe <= w_hsynChain[DLY-1:0];
         r_vsynPipe <= w_vsynChain[DLY-1:0];
         r_rgb      <= (w_hblkChain[DLY-1] | w_vblkChain[DLY-1]) ? '0 : iRGB;
      end
   end

   // Strobes last exactly one MCLK after the wrapping tick and clear otherwise.
   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         r_lineStart  <= 1'b0;
         r_frameStart <= 1'b0;
      end else begin
         r_lineStart  <= PCE && w_hWrap;
         r_frameStart <= PCE && w_hWrap && w_vWrap;
      end
   end

   assign HPOS        = r_hcnt;
   assign VPOS        = r_vcnt;
   assign HBLK        = w_hblkChain[DLY];
   assign VBLK        = w_vblkChain[DLY];
   assign HSYN        = w_hsynChain[DLY];
   assign VSYN        = w_vsynChain[DLY];
   assign DE          = ~(w_hblkChain[DLY] | w_vblkChain[DLY]);
   assign oRGB        = r_rgb;
   assign LINE_START  = r_lineStart;
   assign FRAME_START = r_frameStart;

endmodule

// File: tb/tb_hv_timing_gen.sv
// Testbench for hv_timing_gen. dutA uses the default 288x224 geometry with
// DLY=1 and PCE every 4th clock; dutB uses a tiny raster with DLY=3 so whole
// frames, offset loading and clamping can be exercised quickly.
module tb_hv_timing_gen;

   logic clock = 1'b0;
   logic reset;

   logic        pceA, pceB;
   logic [3:0]  hofsA, hofsB;
   logic [2:0]  vofsA, vofsB;
   logic [11:0] rgbInA, rgbInB;

   logic [8:0]  hposA, vposA, hposB, vposB;
   logic        hblkA, vblkA, hsynA, vsynA, deA, lsA, fsA;
   logic        hblkB, vblkB, hsynB, vsynB, deB, lsB, fsB;
   logic [11:0] rgbOutA, rgbOutB;

   logic lsSeenA, fsSeenA, lsSeenB, fsSeenB;

   int nCompared   = 0;
   int nMismatched = 0;

   // Free-running system clock.
   always #5 clock = ~clock;

   hv_timing_gen dutA (
      .MCLK(clock), .RESET(reset), .PCE(pceA), .HOFS(hofsA), .VOFS(vofsA),
      .iRGB(rgbInA), .HPOS(hposA), .VPOS(vposA), .HBLK(hblkA), .VBLK(vblkA),
      .HSYN(hsynA), .VSYN(vsynA), .DE(deA), .oRGB(rgbOutA),
      .LINE_START(lsA), .FRAME_START(fsA)
   );

   hv_timing_gen #(
      .H_ACTIVE(10), .H_SKIP_FROM(13), .H_SKIP_TO(16), .H_LAST(19),
      .HS_START(11), .HS_WIDTH(2),
      .V_ACTIVE(6), .V_SKIP_FROM(9), .V_SKIP_TO(12), .V_LAST(14),
      .VS_START(7), .VS_WIDTH(2), .DLY(3)
   ) dutB (
      .MCLK(clock), .RESET(reset), .PCE(pceB), .HOFS(hofsB), .VOFS(vofsB),
      .iRGB(rgbInB), .HPOS(hposB), .VPOS(vposB), .HBLK(hblkB), .VBLK(vblkB),
      .HSYN(hsynB), .VSYN(vsynB), .DE(deB), .oRGB(rgbOutB),
      .LINE_START(lsB), .FRAME_START(fsB)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // One dutA pixel tick, PCE period of 4 clocks; strobes sampled right after the tick.
   task automatic applyStimulusA();
      @(negedge clock);
      pceA = 1'b1;
      @(negedge clock);
      pceA    = 1'b0;
      lsSeenA = lsA;
      fsSeenA = fsA;
      repeat (2) @(negedge clock);
   endtask

   task automatic applyTicksA(input int n);
      for (int i = 0; i < n; i++) applyStimulusA();
   endtask

   // One dutB pixel tick, PCE period of 2 clocks.
   task automatic applyStimulusB();
      @(negedge clock);
      pceB = 1'b1;
      @(negedge clock);
      pceB    = 1'b0;
      lsSeenB = lsB;
      fsSeenB = fsB;
   endtask

   // Hand-computed first line of dutB (index = ticks since reset release).
   int hposTbl [22] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,16,17,18,19,0,1,2,3};
   int hblkTbl [22] = '{1,1,1,0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1,0};
   int hsynTbl [22] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,0,1,1,1,1,1,1};

   // Directed sequence: dutA geometry/strobe/hold/reset, then dutB frames.
   initial begin
      int lineTicks;
      int holdStrobes;
      int lsCountB;
      int fsCountB;
      logic wrapped;
      int p, l, fr, vcntE, hsE, vsE;

      reset  = 1'b1;
      pceA   = 1'b0;  pceB  = 1'b0;
      hofsA  = 4'd0;  hofsB = 4'd0;
      vofsA  = 3'd0;  vofsB = 3'd0;
      rgbInA = 12'hA5C;
      rgbInB = 12'hFFF;
      repeat (3) @(negedge clock);

      checkOutput("A reset hpos", hposA, 0);
      checkOutput("A reset vpos", vposA, 0);
      checkOutput("A reset hblk", hblkA, 1);
      checkOutput("A reset vblk", vblkA, 1);
      checkOutput("A reset hsyn", hsynA, 1);
      checkOutput("A reset vsyn", vsynA, 1);
      checkOutput("A reset de", deA, 0);
      checkOutput("A reset rgb", rgbOutA, 0);
      checkOutput("A reset ls", lsA, 0);
      checkOutput("A reset fs", fsA, 0);
      reset = 1'b0;

      applyStimulusA();
      checkOutput("A first tick hpos", hposA, 1);
      checkOutput("A first tick vpos", vposA, 0);
      checkOutput("A first tick hblk", hblkA, 0);
      checkOutput("A first tick de", deA, 1);
      checkOutput("A first tick rgb", rgbOutA, 12'hA5C);
      checkOutput("A no strobe on release", lsSeenA, 0);

      applyTicksA(287);
      checkOutput("A hpos 288", hposA, 288);
      checkOutput("A hblk at hpos 288", hblkA, 0);
      applyStimulusA();
      checkOutput("A hblk at hpos 289", hblkA, 1);
      checkOutput("A de at hpos 289", deA, 0);
      checkOutput("A rgb at hpos 289", rgbOutA, 0);

      applyTicksA(22);
      checkOutput("A hsyn at hpos 311", hsynA, 1);
      applyStimulusA();
      checkOutput("A hsyn at hpos 312", hsynA, 0);
      applyTicksA(23);
      checkOutput("A hpos 335", hposA, 335);
      checkOutput("A hsyn at hpos 335", hsynA, 0);
      applyStimulusA();
      checkOutput("A hsyn at hpos 336", hsynA, 1);

      applyTicksA(6);
      checkOutput("A hpos 342", hposA, 342);
      applyStimulusA();
      checkOutput("A skip to 471", hposA, 471);
      applyTicksA(40);
      checkOutput("A hpos 511", hposA, 511);
      checkOutput("A vpos before wrap", vposA, 0);
      applyStimulusA();
      checkOutput("A wrap hpos", hposA, 0);
      checkOutput("A wrap vpos", vposA, 1);
      checkOutput("A wrap line strobe", lsSeenA, 1);
      checkOutput("A wrap no frame strobe", fsSeenA, 0);
      checkOutput("A strobe cleared", lsA, 0);

      // Offset written mid-frame must not move this frame's HSYN.
      hofsA = 4'd5;
      applyTicksA(311);
      checkOutput("A hofs pending hsyn 311", hsynA, 1);
      applyStimulusA();
      checkOutput("A hofs pending hsyn 312", hsynA, 0);

      holdStrobes = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (lsA || fsA) holdStrobes++;
      end
      checkOutput("A hold hpos", hposA, 312);
      checkOutput("A hold vpos", vposA, 1);
      checkOutput("A hold hsyn", hsynA, 0);
      checkOutput("A hold strobes", holdStrobes, 0);
      applyStimulusA();
      checkOutput("A resume hpos", hposA, 313);

      lineTicks = 313;
      wrapped   = 1'b0;
      for (int i = 0; i < 600 && !wrapped; i++) begin
         applyStimulusA();
         lineTicks++;
         if (lsSeenA) wrapped = 1'b1;
      end
      checkOutput("A line wrap reached", wrapped, 1);
      checkOutput("A line length", lineTicks, 384);
      checkOutput("A line2 vpos", vposA, 2);

      applyTicksA(150);
      checkOutput("A hpos 150", hposA, 150);
      #2 reset = 1'b1;
      #1;
      checkOutput("A async reset hpos", hposA, 0);
      checkOutput("A async reset vpos", vposA, 0);
      checkOutput("A async reset hblk", hblkA, 1);
      checkOutput("A async reset vblk", vblkA, 1);
      checkOutput("A async reset hsyn", hsynA, 1);
      checkOutput("A async reset de", deA, 0);
      checkOutput("A async reset rgb", rgbOutA, 0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulusA();
      checkOutput("A restart hpos", hposA, 1);
      checkOutput("A restart no strobe", lsSeenA, 0);

      // dutB: two full frames with offsets changed partway through frame 0.
      lsCountB = 0;
      fsCountB = 0;
      for (int t = 0; t <= 470; t++) begin
         if (t > 0) applyStimulusB();
         if (t == 100) begin
            hofsB = 4'b0111;
            vofsB = 3'b100;
         end
         if (t <= 21) begin
            checkOutput($sformatf("B hpos t=%0d", t), hposB, hposTbl[t]);
            checkOutput($sformatf("B hblk t=%0d", t), hblkB, hblkTbl[t]);
            checkOutput($sformatf("B hsyn t=%0d", t), hsynB, hsynTbl[t]);
            checkOutput($sformatf("B de t=%0d", t), deB, (hblkTbl[t] == 0));
            checkOutput($sformatf("B rgb t=%0d", t), rgbOutB, (hblkTbl[t] == 0) ? 12'hFFF : 12'h000);
            checkOutput($sformatf("B vpos t=%0d", t), vposB, (t >= 18) ? 1 : 0);
         end
         if (t > 0) begin
            if (lsSeenB) lsCountB++;
            if (fsSeenB) begin
               fsCountB++;
               checkOutput($sformatf("B frame strobe with line strobe t=%0d", t), lsSeenB, 1);
            end
         end
         p     = t % 18;
         l     = (t / 18) % 13;
         fr    = t / 234;
         vcntE = (l < 10) ? l : l + 2;
         hsE   = (fr == 0) ? 11 : 12;
         vsE   = (fr == 0) ? 7 : 6;
         if (p == 5) begin
            checkOutput($sformatf("B vpos t=%0d", t), vposB, vcntE);
            checkOutput($sformatf("B vblk t=%0d", t), vblkB, (vcntE >= 6));
            checkOutput($sformatf("B vsyn t=%0d", t), vsynB, !((vcntE >= vsE) && (vcntE < vsE + 2)));
            checkOutput($sformatf("B line rgb t=%0d", t), rgbOutB, (vcntE < 6) ? 12'hFFF : 12'h000);
         end
         if (p >= 14 && p <= 16) begin
            checkOutput($sformatf("B hsyn shift t=%0d", t), hsynB, !(((p - 3) >= hsE) && ((p - 3) < hsE + 2)));
         end
      end
      checkOutput("B line strobe count", lsCountB, 26);
      checkOutput("B frame strobe count", fsCountB, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
